// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed note display: 4-bit note codes and
// the active-low segment patterns {P,G,F,E,D,C,B,A} they map to.
package seg_pkg;

  localparam logic [3:0] NOTE_C     = 4'd0;
  localparam logic [3:0] NOTE_D     = 4'd1;
  localparam logic [3:0] NOTE_E     = 4'd2;
  localparam logic [3:0] NOTE_F     = 4'd3;
  localparam logic [3:0] NOTE_G     = 4'd4;
  localparam logic [3:0] NOTE_A     = 4'd5;
  localparam logic [3:0] NOTE_B     = 4'd6;
  localparam logic [3:0] NOTE_C_HI  = 4'd7;
  localparam logic [3:0] NOTE_D_HI  = 4'd8;
  localparam logic [3:0] NOTE_E_HI  = 4'd9;
  localparam logic [3:0] CODE_BLANK = 4'd15;

  localparam logic [7:0] SEG_C    = 8'hC6;
  localparam logic [7:0] SEG_D    = 8'hC0;
  localparam logic [7:0] SEG_E    = 8'h86;
  localparam logic [7:0] SEG_F    = 8'h8E;
  localparam logic [7:0] SEG_G    = 8'h82;
  localparam logic [7:0] SEG_A    = 8'h88;
  localparam logic [7:0] SEG_B    = 8'h80;
  localparam logic [7:0] SEG_C_DP = 8'h46;
  localparam logic [7:0] SEG_D_DP = 8'h40;
  localparam logic [7:0] SEG_E_DP = 8'h06;
  localparam logic [7:0] SEG_OFF  = 8'hFF;

endpackage

// File: rtl/note_seg_decode.sv
// Combinational note-code to segment-pattern map; codes 10..15 are blank.
module note_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [7:0] seg_o
);

  // Code lookup; anything outside the note range turns every segment off.
  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      NOTE_C:    seg_o = SEG_C;
      NOTE_D:    seg_o = SEG_D;
      NOTE_E:    seg_o = SEG_E;
      NOTE_F:    seg_o = SEG_F;
      NOTE_G:    seg_o = SEG_G;
      NOTE_A:    seg_o = SEG_A;
      NOTE_B:    seg_o = SEG_B;
      NOTE_C_HI: seg_o = SEG_C_DP;
      NOTE_D_HI: seg_o = SEG_D_DP;
      NOTE_E_HI: seg_o = SEG_E_DP;
      default:   seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_mux_display.sv
// Time-multiplexed note display: scans NUM_DIGITS anodes with a one-cycle
// ghost guard per slot, double-buffers frames and blinks selected digits.
module seg_mux_display
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] frame_codes,
  input  logic [NUM_DIGITS-1:0]   frame_blink,
  input  logic                    frame_valid,
  output logic                    frame_ready,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_wrap
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [DIV_W-1:0]        div_q, div_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BLK_W-1:0]        blk_cnt_q, blk_cnt_d;
  logic                    blink_ph_q, blink_ph_d;
  logic                    pend_q, pend_d;
  logic [4*NUM_DIGITS-1:0] pend_codes_q, pend_codes_d;
  logic [NUM_DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic [4*NUM_DIGITS-1:0] act_codes_q, act_codes_d;
  logic [NUM_DIGITS-1:0]   act_blink_q, act_blink_d;
  logic                    act_loaded_q, act_loaded_d;
  logic                    ready_q, ready_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    wrap_q, wrap_d;

  logic                    tick_s;
  logic                    scan_end_s;
  logic [3:0]              sel_code_s;
  logic                    sel_blink_s;
  logic [7:0]              sel_seg_s;

  note_seg_decode u_decode (
    .code_i (sel_code_s),
    .seg_o  (sel_seg_s)
  );

  // Divider, scan index, blink phase, frame buffering and output staging.
  always_comb begin
    tick_s       = (div_q == DIV_W'(REFRESH_DIV - 1));
    scan_end_s   = tick_s && (idx_q == IDX_W'(NUM_DIGITS - 1));
    sel_code_s   = act_codes_q[{idx_q, 2'b00} +: 4];
    sel_blink_s  = act_blink_q[idx_q];

    div_d        = tick_s ? '0 : div_q + DIV_W'(1);
    idx_d        = idx_q;
    blk_cnt_d    = blk_cnt_q;
    blink_ph_d   = blink_ph_q;
    pend_d       = pend_q;
    pend_codes_d = pend_codes_q;
    pend_blink_d = pend_blink_q;
    act_codes_d  = act_codes_q;
    act_blink_d  = act_blink_q;
    act_loaded_d = act_loaded_q;

    if (tick_s) begin
      idx_d = scan_end_s ? '0 : idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end

    if (scan_end_s) begin
      if (blk_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blk_cnt_d  = '0;
        blink_ph_d = ~blink_ph_q;
      end else begin
        blk_cnt_d  = blk_cnt_q + BLK_W'(1);
      end
    end else begin
      blk_cnt_d = blk_cnt_q;
    end

    // A pending frame only lands at a scan boundary, so a scan never mixes frames.
    if (scan_end_s && pend_q) begin
      act_codes_d  = pend_codes_q;
      act_blink_d  = pend_blink_q;
      act_loaded_d = 1'b1;
      pend_d       = 1'b0;
    end else if (frame_valid && ready_q) begin
      pend_codes_d = frame_codes;
      pend_blink_d = frame_blink;
      pend_d       = 1'b1;
    end else begin
      pend_d = pend_q;
    end

    ready_d = ~pend_d;
    wrap_d  = scan_end_s;

    // Anodes stay dark until the first frame has been applied after reset.
    if (tick_s || !act_loaded_q) begin
      an_d  = '1;
      seg_d = SEG_OFF;
    end else begin
      an_d  = ~(NUM_DIGITS'(1) << idx_q);
      seg_d = (sel_blink_s && blink_ph_q) ? SEG_OFF : sel_seg_s;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q        <= '0;
      idx_q        <= '0;
      blk_cnt_q    <= '0;
      blink_ph_q   <= 1'b0;
      pend_q       <= 1'b0;
      pend_codes_q <= '0;
      pend_blink_q <= '0;
      act_codes_q  <= {NUM_DIGITS{CODE_BLANK}};
      act_blink_q  <= '0;
      act_loaded_q <= 1'b0;
      ready_q      <= 1'b0;
      seg_q        <= SEG_OFF;
      an_q         <= '1;
      wrap_q       <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      blk_cnt_q    <= blk_cnt_d;
      blink_ph_q   <= blink_ph_d;
      pend_q       <= pend_d;
      pend_codes_q <= pend_codes_d;
      pend_blink_q <= pend_blink_d;
      act_codes_q  <= act_codes_d;
      act_blink_q  <= act_blink_d;
      act_loaded_q <= act_loaded_d;
      ready_q      <= ready_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      wrap_q       <= wrap_d;
    end
  end

  assign frame_ready = ready_q;
  assign seg         = seg_q;
  assign an          = an_q;
  assign frame_wrap  = wrap_q;

endmodule

// File: doc/seg_mux_display.md
SEG_MUX_DISPLAY -- requirements
Module: seg_mux_display

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 Parameter REFRESH_DIV, default 100000: clock cycles per digit slot, minimum 4.
REQ-003 Parameter BLINK_DIV, default 250: scan frames per blink half-period, minimum 1.
REQ-004 clk  input  1: single system clock; all logic on rising edge.
REQ-005 rst_n  input  1: reset, synchronous and active-low.
REQ-006 frame_codes  input  4*NUM_DIGITS: note code per digit; digit k uses bits [4k+3:4k].
REQ-007 frame_blink  input  NUM_DIGITS: per-digit blink enable.
REQ-008 frame_valid  input  1: new frame offered.
REQ-009 frame_ready  output  1: frame slot free; transfer occurs when valid and ready are both high.
REQ-010 seg  output  8: segments {P,G,F,E,D,C,B,A}, active-low.
REQ-011 an  output  NUM_DIGITS: digit anodes, active-low, one-hot-low or all-high.
REQ-012 frame_wrap  output  1: one-cycle pulse when the scan returns to digit 0.

Function
REQ-013 Code map, seg value: 0 C=C6, 1 D=C0, 2 E=86, 3 F=8E, 4 G=82, 5 A=88, 6 B=80, 7 C+DP=46, 8 D+DP=40, 9 E+DP=06, 10-15 blank=FF (hex).
REQ-014 Divider counts 0..REFRESH_DIV-1 and wraps; a refresh tick is the cycle at REFRESH_DIV-1.
REQ-015 On a tick the digit index advances by 1 and wraps from NUM_DIGITS-1 to 0; with NUM_DIGITS=1 it stays 0.
REQ-016 In the cycle after a tick: an = all ones, seg = FF (one-cycle ghost guard).
REQ-017 From the second cycle after a tick until the next guard: an bit[index] = 0, all other bits 1; seg = map(active code[index]).
REQ-018 A digit with active blink bit set shows seg = FF while blink phase = 1; its an bit is still driven low.
REQ-019 Blink phase toggles after every BLINK_DIV index wraps to 0.
REQ-020 Frame handshake: frame_ready = not pending; on transfer, codes and blink are captured into a pending register.
REQ-021 Pending contents copy into the active register on the tick that wraps the index to 0, and pending clears in the same cycle; the displayed frame never changes mid-scan.
REQ-022 A transfer and a pending-apply never coincide, since ready is low while pending; frame_valid with ready low is ignored; data need not be held.
REQ-023 frame_wrap = 1 for exactly the cycle following the tick that wraps the index to 0.
REQ-024 All outputs are registered; no combinational path from inputs to seg, an, or frame_wrap.

Reset
REQ-025 While rst_n = 0 at a clock edge: divider = 0, index = 0, blink phase = 0, pending cleared, active codes = 15 (blank), active blink = 0.
REQ-026 Reset output values: an = all ones, seg = FF, frame_wrap = 0, frame_ready = 0.
REQ-027 frame_ready = 1 from the first cycle after rst_n rises.
REQ-028 Reset asserted mid-frame discards pending and active frames; the scan restarts at digit 0.

Structure
REQ-029 Package seg_pkg holds the 4-bit note-code constants, the BLANK code (15), and the 8-bit segment pattern constants.
REQ-030 One sub-module, note_seg_decode, performs the combinational code-to-pattern map, one instance on the selected digit.

Verification
Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.
REQ-031 Reset release with no frame: an = F and seg = FF for 40 cycles; frame_ready = 1 from the cycle after release.
REQ-032 Send codes {3,2,1,0} (digit3..0), blink 0 -> after the next wrap, sequence an = E/C0... wait-free order: an = E with seg C6, then D with C0, then B with 86, then 7 with 8E; each slot is 3 drive cycles plus 1 guard cycle with an = F.
REQ-033 Send a second frame mid-scan -> frame_ready = 0 until the wrap; the digits still to be scanned in the current frame show old codes; the new codes start at digit 0; frame_wrap pulses once per 16 cycles.
REQ-034 Hold frame_valid while frame_ready = 0 with a third frame -> it is not captured, and exactly one transfer follows ready rising.
REQ-035 Blink mask 0001 with code 9 on digit 0 -> digit 0 shows seg 06 for 2 frames, then FF for 2 frames (an bit 0 still low); other digits are unaffected.
REQ-036 Assert rst_n = 0 for one cycle mid-slot with a pending frame -> next cycle an = F and seg = FF; all digits blank afterwards; frame_ready = 1 again.
